// File: rtl/alu_div_sequencer_if.sv
// Execute-stage <-> MOD/DIV sequencer bus: operation request, results and pipeline control.
interface alu_div_sequencer_if #(
    parameter int DIV_WIDTH = 16
);
    logic [3:0]           ALUCtrl;
    logic                 Start;
    logic                 Flush;
    logic [DIV_WIDTH-1:0] OpA;
    logic [DIV_WIDTH-1:0] OpB;
    logic [DIV_WIDTH-1:0] Quotient;
    logic [DIV_WIDTH-1:0] Remainder;
    logic                 DivByZero;
    logic                 Busy;
    logic                 Done;
    logic                 Stall;

    modport master (
        output ALUCtrl, Start, Flush, OpA, OpB,
        input  Quotient, Remainder, DivByZero, Busy, Done, Stall
    );

    modport slave (
        input  ALUCtrl, Start, Flush, OpA, OpB,
        output Quotient, Remainder, DivByZero, Busy, Done, Stall
    );
endinterface

// File: rtl/alu_div_sequencer.sv
// Multi-cycle restoring divider for ALU MOD/DIV (ALUCtrl 4'b0111) with pipeline stall.
// Optional macro DIV_SIGNED_EN: two's-complement operands, sign fix-up applied at result load.
module alu_div_sequencer #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 Clock,
    input  logic                 Reset_n,
    alu_div_sequencer_if.slave   bus
);
    localparam int                   CNT_W    = $clog2(DIV_WIDTH);
    localparam logic [3:0]           ALU_DIV  = 4'b0111;
    localparam logic [CNT_W-1:0]     CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]     CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(DIV_WIDTH - 1);
    localparam logic [DIV_WIDTH-1:0] W_ZERO   = {DIV_WIDTH{1'b0}};
    localparam logic [DIV_WIDTH-1:0] W_ONES   = {DIV_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0] rem_q, rem_d;
    logic [DIV_WIDTH-1:0] dvd_q, dvd_d;
    logic [DIV_WIDTH-1:0] dvs_q, dvs_d;
    logic [DIV_WIDTH-1:0] quot_q, quot_d;
    logic [DIV_WIDTH-1:0] remo_q, remo_d;
    logic                 dbz_q, dbz_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic                 start_acc_s;
    logic [DIV_WIDTH:0]   rem_sh_s;
    logic [DIV_WIDTH:0]   trial_s;
    logic                 q_bit_s;
    logic [DIV_WIDTH-1:0] rem_next_s;
    logic [DIV_WIDTH-1:0] quot_next_s;
    logic [DIV_WIDTH-1:0] opa_mag_s;
    logic [DIV_WIDTH-1:0] opb_mag_s;
    logic [DIV_WIDTH-1:0] quot_fix_s;
    logic [DIV_WIDTH-1:0] rem_fix_s;

`ifdef DIV_SIGNED_EN
    logic q_neg_q, q_neg_d;
    logic r_neg_q, r_neg_d;

    function automatic logic [DIV_WIDTH-1:0] negate(input logic [DIV_WIDTH-1:0] v);
        return ~v + {{(DIV_WIDTH-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [DIV_WIDTH-1:0] magnitude(input logic [DIV_WIDTH-1:0] v);
        return v[DIV_WIDTH-1] ? negate(v) : v;
    endfunction
`endif

    // Start qualification, one restoring-division step, and operand/result sign handling.
    always_comb begin
        start_acc_s = bus.Start && (bus.ALUCtrl == ALU_DIV) && (state_q != ST_RUN) && !bus.Flush;
        // rem < divisor always holds, so the 17-bit trial never overflows and its MSB is the sign.
        rem_sh_s    = {rem_q, dvd_q[DIV_WIDTH-1]};
        trial_s     = rem_sh_s - {1'b0, dvs_q};
        q_bit_s     = ~trial_s[DIV_WIDTH];
        rem_next_s  = q_bit_s ? trial_s[DIV_WIDTH-1:0] : rem_sh_s[DIV_WIDTH-1:0];
        quot_next_s = {dvd_q[DIV_WIDTH-2:0], q_bit_s};
`ifdef DIV_SIGNED_EN
        opa_mag_s   = magnitude(bus.OpA);
        opb_mag_s   = magnitude(bus.OpB);
        quot_fix_s  = q_neg_q ? negate(quot_next_s) : quot_next_s;
        rem_fix_s   = r_neg_q ? negate(rem_next_s) : rem_next_s;
`else
        opa_mag_s   = bus.OpA;
        opb_mag_s   = bus.OpB;
        quot_fix_s  = quot_next_s;
        rem_fix_s   = rem_next_s;
`endif
    end

    // Next-state and datapath update for IDLE / RUN / DONE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        quot_d  = quot_q;
        remo_d  = remo_q;
        dbz_d   = dbz_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
`ifdef DIV_SIGNED_EN
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
`endif
        if (bus.Flush) begin
            state_d = ST_IDLE;
            cnt_d   = CNT_ZERO;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_acc_s) begin
                        dvd_d = opa_mag_s;
                        dvs_d = opb_mag_s;
                        rem_d = W_ZERO;
                        cnt_d = CNT_ZERO;
`ifdef DIV_SIGNED_EN
                        q_neg_d = bus.OpA[DIV_WIDTH-1] ^ bus.OpB[DIV_WIDTH-1];
                        r_neg_d = bus.OpA[DIV_WIDTH-1];
`endif
                        if (bus.OpB == W_ZERO) begin
                            state_d = ST_DONE;
                            quot_d  = W_ONES;
                            remo_d  = bus.OpA;
                            dbz_d   = 1'b1;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_RUN;
                            busy_d  = 1'b1;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    rem_d = rem_next_s;
                    dvd_d = quot_next_s;
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_DONE;
                        quot_d  = quot_fix_s;
                        remo_d  = rem_fix_s;
                        dbz_d   = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        busy_d  = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                end
            endcase
        end
    end

    // State, datapath and registered output flops.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= CNT_ZERO;
            rem_q   <= W_ZERO;
            dvd_q   <= W_ZERO;
            dvs_q   <= W_ZERO;
            quot_q  <= W_ZERO;
            remo_q  <= W_ZERO;
            dbz_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef DIV_SIGNED_EN
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            quot_q  <= quot_d;
            remo_q  <= remo_d;
            dbz_q   <= dbz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef DIV_SIGNED_EN
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
`endif
        end
    end

    assign bus.Quotient  = quot_q;
    assign bus.Remainder = remo_q;
    assign bus.DivByZero = dbz_q;
    assign bus.Busy      = busy_q;
    assign bus.Done      = done_q;
    // Stall covers the start cycle combinationally so the pipeline freezes before Busy rises.
    assign bus.Stall     = Reset_n && (busy_q || start_acc_s);
endmodule

// File: tb/tb_alu_div_sequencer.sv
// Randomized + directed bench for alu_div_sequencer against a cycle-timeline reference model.
module tb_alu_div_sequencer;
    logic Clock;
    logic Reset_n;
    int   n_cmp;
    int   n_bad;

    alu_div_sequencer_if #(.DIV_WIDTH(16)) bus ();

    alu_div_sequencer #(.DIV_WIDTH(16)) dut (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // Reference model: cycles of RUN left, expected Done, and the published result.
    int          m_left;
    logic        m_done;
    logic [15:0] m_q, m_r, p_q, p_r;
    logic        m_z, p_z;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic acc_now();
        return bus.Start && (bus.ALUCtrl == 4'b0111) && (m_left == 0) && !bus.Flush;
    endfunction

    function automatic void calc(input logic [15:0] a, input logic [15:0] b,
                                 output logic [15:0] q, output logic [15:0] r, output logic z);
        int sa;
        int sb;
        sa = 0;
        sb = 0;
        if (b == 16'h0000) begin
            q = 16'hFFFF;
            r = a;
            z = 1'b1;
        end else begin
`ifdef DIV_SIGNED_EN
            sa = int'($signed(a));
            sb = int'($signed(b));
            q  = 16'(sa / sb);
            r  = 16'(sa % sb);
`else
            q  = a / b;
            r  = a % b;
`endif
            z  = 1'b0;
        end
    endfunction

    always @(posedge Clock or negedge Reset_n) begin
        logic [15:0] cq, cr;
        logic        cz;
        if (!Reset_n) begin
            m_left <= 0;
            m_done <= 1'b0;
            m_q    <= 16'h0000;
            m_r    <= 16'h0000;
            m_z    <= 1'b0;
        end else if (bus.Flush) begin
            m_left <= 0;
            m_done <= 1'b0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            m_done <= (m_left == 1);
            if (m_left == 1) begin
                m_q <= p_q;
                m_r <= p_r;
                m_z <= p_z;
            end
        end else if (acc_now()) begin
            calc(bus.OpA, bus.OpB, cq, cr, cz);
            if (cz) begin
                m_done <= 1'b1;
                m_q    <= cq;
                m_r    <= cr;
                m_z    <= cz;
            end else begin
                m_left <= 16;
                m_done <= 1'b0;
                p_q    <= cq;
                p_r    <= cr;
                p_z    <= cz;
            end
        end else begin
            m_done <= 1'b0;
        end
    end

    always @(negedge Clock) begin
        chk("busy",      32'(bus.Busy),      32'(m_left > 0));
        chk("done",      32'(bus.Done),      32'(m_done));
        chk("quotient",  32'(bus.Quotient),  32'(m_q));
        chk("remainder", 32'(bus.Remainder), 32'(m_r));
        chk("divbyzero", 32'(bus.DivByZero), 32'(m_z));
        chk("stall",     32'(bus.Stall),     32'(Reset_n && ((m_left > 0) || acc_now())));
    end

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic set_in(input logic s, input logic [3:0] c, input logic f,
                          input logic [15:0] a, input logic [15:0] b);
        bus.Start   = s;
        bus.ALUCtrl = c;
        bus.Flush   = f;
        bus.OpA     = a;
        bus.OpB     = b;
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, output int lat);
        set_in(1'b1, 4'b0111, 1'b0, a, b);
        step();
        bus.Start = 1'b0;
        lat = 0;
        if (bus.Done === 1'b1) begin
            lat = 1;
        end else begin
            for (int i = 2; i <= 40; i++) begin
                step();
                if (bus.Done === 1'b1) begin
                    lat = i;
                    break;
                end
            end
        end
    endtask

    initial begin
        int lat;
        n_cmp   = 0;
        n_bad   = 0;
        Reset_n = 1'b0;
        set_in(1'b0, 4'b0000, 1'b0, 16'h0000, 16'h0000);
        #22;
        chk("rst_quot",  32'(bus.Quotient),  32'h0);
        chk("rst_rem",   32'(bus.Remainder), 32'h0);
        chk("rst_stall", 32'(bus.Stall),     32'h0);
        Reset_n = 1'b1;
        step();

        run_op(16'd100, 16'd7, lat);
        chk("udiv_lat", 32'(lat), 32'd17);
        chk("udiv_q", 32'(bus.Quotient), 32'd14);
        chk("udiv_r", 32'(bus.Remainder), 32'd2);
        chk("udiv_z", 32'(bus.DivByZero), 32'd0);
        step();

        run_op(16'h1234, 16'h0000, lat);
        chk("dbz_lat", 32'(lat), 32'd1);
        chk("dbz_q", 32'(bus.Quotient), 32'hFFFF);
        chk("dbz_r", 32'(bus.Remainder), 32'h1234);
        chk("dbz_z", 32'(bus.DivByZero), 32'd1);
        chk("dbz_busy", 32'(bus.Busy), 32'd0);
        step();

        set_in(1'b1, 4'b0100, 1'b0, 16'd9, 16'd3);
        chk("wrongop_stall", 32'(bus.Stall), 32'd0);
        step();
        bus.Start = 1'b0;
        step();
        chk("wrongop_busy", 32'(bus.Busy), 32'd0);
        chk("wrongop_q", 32'(bus.Quotient), 32'hFFFF);

        set_in(1'b1, 4'b0111, 1'b0, 16'hFFFF, 16'd3);
        step();
        bus.Start = 1'b0;
        repeat (4) step();
        bus.Flush = 1'b1;
        step();
        bus.Flush = 1'b0;
        chk("flush_busy", 32'(bus.Busy), 32'd0);
        chk("flush_q", 32'(bus.Quotient), 32'hFFFF);
        repeat (20) step();
        set_in(1'b1, 4'b0111, 1'b1, 16'd40, 16'd4);
        step();
        set_in(1'b0, 4'b0111, 1'b0, 16'd40, 16'd4);
        chk("flush_start_busy", 32'(bus.Busy), 32'd0);
        chk("flush_start_done", 32'(bus.Done), 32'd0);

        set_in(1'b1, 4'b0111, 1'b0, 16'hFFFF, 16'd3);
        step();
        bus.Start = 1'b0;
        repeat (7) step();
        #2 Reset_n = 1'b0;
        #1;
        chk("rstmid_busy", 32'(bus.Busy), 32'd0);
        chk("rstmid_stall", 32'(bus.Stall), 32'd0);
        chk("rstmid_q", 32'(bus.Quotient), 32'd0);
        chk("rstmid_r", 32'(bus.Remainder), 32'd0);
        #10 Reset_n = 1'b1;
        step();
        run_op(16'hFFFF, 16'd3, lat);
        chk("after_rst_lat", 32'(lat), 32'd17);
`ifdef DIV_SIGNED_EN
        chk("after_rst_q", 32'(bus.Quotient), 32'h0000);
        chk("after_rst_r", 32'(bus.Remainder), 32'hFFFF);
`else
        chk("after_rst_q", 32'(bus.Quotient), 32'h5555);
        chk("after_rst_r", 32'(bus.Remainder), 32'h0000);
`endif

        run_op(16'd50, 16'd8, lat);
        chk("b2b_lat", 32'(lat), 32'd17);
        chk("b2b_q", 32'(bus.Quotient), 32'd6);
        chk("b2b_r", 32'(bus.Remainder), 32'd2);

`ifdef DIV_SIGNED_EN
        run_op(16'hFFF9, 16'd2, lat);
        chk("sdiv_q", 32'(bus.Quotient), 32'hFFFD);
        chk("sdiv_r", 32'(bus.Remainder), 32'hFFFF);
        run_op(16'h8000, 16'hFFFF, lat);
        chk("smin_q", 32'(bus.Quotient), 32'h8000);
        chk("smin_r", 32'(bus.Remainder), 32'h0000);
`endif
        step();

        for (int k = 0; k < 4000; k++) begin
            bus.Start   = ($urandom_range(0, 3) == 0);
            bus.ALUCtrl = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'b0111;
            bus.Flush   = ($urandom_range(0, 60) == 0);
            bus.OpA     = 16'($urandom);
            if ($urandom_range(0, 9) == 0) begin
                bus.OpB = 16'h0000;
            end else if ($urandom_range(0, 1) == 0) begin
                bus.OpB = 16'($urandom_range(1, 20));
            end else begin
                bus.OpB = 16'($urandom);
            end
            step();
        end
        set_in(1'b0, 4'b0000, 1'b0, 16'h0000, 16'h0000);
        repeat (20) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
